// File: rtl/nanov_fetch_ctrl.sv
// Serial instruction fetch sequencer: streams instruction bits from an SPI flash (mode 0,
// read command) into the nanoV core, restarting on PC load and pausing on stall.
module nanov_fetch_ctrl #(
   parameter int unsigned ADDR_BITS = 24,
   parameter logic [7:0]  READ_CMD  = 8'h03,
   parameter int unsigned CS_GAP    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pc_load,
   input  logic [ADDR_BITS-1:0] pc_addr,
   input  logic                 stop,
   input  logic                 stall,
   input  logic                 spi_miso,
   output logic                 spi_cs_n,
   output logic                 spi_sck,
   output logic                 spi_mosi,
   output logic                 instr_bit,
   output logic                 instr_valid,
   output logic                 word_done,
   output logic [ADDR_BITS-1:0] fetch_addr,
   output logic                 busy
);

   localparam int unsigned HdrBits = 8 + ADDR_BITS;

   typedef enum logic [2:0] {StIdle, StGap, StCmd, StAddr, StData} state_e;

   state_e               state_q, state_d;
   logic [7:0]           gap_q, gap_d;
   logic [7:0]           bit_q, bit_d;
   logic                 sck_q, sck_d;
   logic                 cs_n_q, cs_n_d;
   logic                 mosi_q, mosi_d;
   logic                 ibit_q, ibit_d;
   logic                 ivalid_q, ivalid_d;
   logic                 wdone_q, wdone_d;
   logic [ADDR_BITS-1:0] faddr_q, faddr_d;
   logic [HdrBits-1:0]   hdr_q, hdr_d;

   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      bit_d    = bit_q;
      sck_d    = sck_q;
      cs_n_d   = cs_n_q;
      mosi_d   = mosi_q;
      ibit_d   = ibit_q;
      ivalid_d = 1'b0;
      wdone_d  = 1'b0;
      faddr_d  = faddr_q;
      hdr_d    = hdr_q;

      if (pc_load) begin
         state_d = StGap;
         gap_d   = '0;
         bit_d   = '0;
         sck_d   = 1'b0;
         cs_n_d  = 1'b1;
         mosi_d  = 1'b0;
         // Word-aligned: the low two address bits are dropped.
         faddr_d = pc_addr & ~ADDR_BITS'(3);
      end else if (stop && (state_q != StIdle)) begin
         state_d = StIdle;
         bit_d   = '0;
         sck_d   = 1'b0;
         cs_n_d  = 1'b1;
         mosi_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StGap: begin
               if (gap_q == 8'(CS_GAP)) begin
                  state_d          = StCmd;
                  cs_n_d           = 1'b0;
                  bit_d            = '0;
                  {mosi_d, hdr_d}  = {READ_CMD, faddr_q, 1'b0};
               end else begin
                  gap_d = gap_q + 8'd1;
               end
            end
            StCmd, StAddr: begin
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d           = 1'b0;
                  {mosi_d, hdr_d} = {hdr_q, 1'b0};
                  bit_d           = bit_q + 8'd1;
                  if ((state_q == StCmd) && (bit_q == 8'd7)) begin
                     state_d = StAddr;
                     bit_d   = '0;
                  end else if ((state_q == StAddr) && (bit_q == 8'(ADDR_BITS - 1))) begin
                     state_d = StData;
                     bit_d   = '0;
                     mosi_d  = 1'b0;
                  end
               end
            end
            StData: begin
               // Stall only blocks the rising edge, so a bit already in flight completes.
               if (!sck_q) begin
                  if (!stall) sck_d = 1'b1;
               end else begin
                  sck_d    = 1'b0;
                  ibit_d   = spi_miso;
                  ivalid_d = 1'b1;
                  if (bit_q == 8'd31) begin
                     wdone_d = 1'b1;
                     bit_d   = '0;
                     faddr_d = faddr_q + ADDR_BITS'(4);
                  end else begin
                     bit_d = bit_q + 8'd1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         gap_q    <= '0;
         bit_q    <= '0;
         sck_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         mosi_q   <= 1'b0;
         ibit_q   <= 1'b0;
         ivalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         faddr_q  <= '0;
         hdr_q    <= '0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         bit_q    <= bit_d;
         sck_q    <= sck_d;
         cs_n_q   <= cs_n_d;
         mosi_q   <= mosi_d;
         ibit_q   <= ibit_d;
         ivalid_q <= ivalid_d;
         wdone_q  <= wdone_d;
         faddr_q  <= faddr_d;
         hdr_q    <= hdr_d;
      end
   end

   assign spi_cs_n    = cs_n_q;
   assign spi_sck     = sck_q;
   assign spi_mosi    = mosi_q;
   assign instr_bit   = ibit_q;
   assign instr_valid = ivalid_q;
   assign word_done   = wdone_q;
   assign fetch_addr  = faddr_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_nanov_fetch_ctrl.sv
// Bench for nanov_fetch_ctrl: SPI flash model feeding a bit scoreboard, table-driven fetches
// plus hand-written stall, restart and reset sequences.
module tb_nanov_fetch_ctrl;
   localparam int unsigned AB = 24;

   logic          clk = 1'b0;
   logic          rst, pc_load, stop, stall, spi_miso;
   logic [AB-1:0] pc_addr;
   logic          spi_cs_n, spi_sck, spi_mosi, instr_bit, instr_valid, word_done, busy;
   logic [AB-1:0] fetch_addr;

   nanov_fetch_ctrl #(.ADDR_BITS(AB), .READ_CMD(8'h03), .CS_GAP(2)) dut (
      .clk(clk), .rst(rst), .pc_load(pc_load), .pc_addr(pc_addr), .stop(stop),
      .stall(stall), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
      .spi_mosi(spi_mosi), .instr_bit(instr_bit), .instr_valid(instr_valid),
      .word_done(word_done), .fetch_addr(fetch_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          b;
      logic          wd;
      logic [AB-1:0] fa;
   } exp_t;

   typedef struct {
      logic [AB-1:0] addr;
      logic [31:0]   hdr;
      int            words;
      logic [AB-1:0] fa1;
      logic [AB-1:0] end_fa;
      logic [31:0]   w0;
      logic [31:0]   wl;
   } vec_t;

   int          n_vec = 0, n_err = 0;
   logic        sck_prev = 1'b0;
   int          hdr_bits = 0, data_bits = 0, sck_rises = 0, wd_cnt = 0, rx_n = 0;
   logic [31:0] hdr_cap = '0, rx_sr = '0;
   exp_t        exp_q[$];
   logic [31:0] rx_words[$];
   vec_t        vt[4];

   function automatic logic [31:0] flash_word(input logic [AB-1:0] a);
      case (a)
         24'h000100: return 32'hDEADBEEF;
         24'h000104: return 32'h12345678;
         24'h000200: return 32'hCAFEF00D;
         24'hFFFFFC: return 32'h0BADC0DE;
         24'h000000: return 32'hFEEDFACE;
         default:    return {a, 8'hC3};
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: advance to the falling edge, then run the flash model and scoreboard.
   task automatic cyc();
      exp_t          e;
      logic [AB-1:0] wa;
      logic [31:0]   w;
      int            j;
      @(negedge clk);
      if (spi_cs_n) begin
         hdr_bits  = 0;
         hdr_cap   = '0;
         data_bits = 0;
         sck_rises = 0;
         rx_n      = 0;
         rx_sr     = '0;
         spi_miso  = 1'b0;
         exp_q.delete();
      end else begin
         if (word_done && !instr_valid) chk("word_done_without_valid", 1, 0);
         if (instr_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("instr_bit", instr_bit, e.b);
               chk("word_done", word_done, e.wd);
               chk("fetch_addr", fetch_addr, e.fa);
            end
            rx_sr = {rx_sr[30:0], instr_bit};
            rx_n++;
            if (rx_n == 32) begin
               rx_words.push_back(rx_sr);
               rx_n = 0;
            end
         end
         if (word_done) wd_cnt++;
         if (spi_sck && !sck_prev) begin
            sck_rises++;
            if (hdr_bits < 32) begin
               hdr_cap = {hdr_cap[30:0], spi_mosi};
               hdr_bits++;
            end else begin
               chk("mosi_zero_in_data", spi_mosi, 0);
               wa       = hdr_cap[AB-1:0] + AB'(4 * (data_bits / 32));
               j        = data_bits % 32;
               w        = flash_word(wa);
               spi_miso = w[31-j];
               e.b      = w[31-j];
               e.wd     = (j == 31);
               e.fa     = (j == 31) ? wa + AB'(4) : wa;
               exp_q.push_back(e);
               data_bits++;
            end
         end
      end
      sck_prev = spi_sck;
   endtask

   task automatic start_txn(input logic [AB-1:0] a, input logic [31:0] exp_hdr,
                            input bit with_stop);
      int lat;
      rx_words.delete();
      wd_cnt  = 0;
      pc_addr = a;
      pc_load = 1'b1;
      if (with_stop) stop = 1'b1;
      cyc();
      pc_load = 1'b0;
      stop    = 1'b0;
      chk("busy_after_load", busy, 1);
      chk("cs_high_after_load", spi_cs_n, 1);
      lat = 0;
      while (spi_cs_n && lat < 20) begin
         cyc();
         lat++;
      end
      chk("cs_fall_latency", lat, 3);
      lat = 0;
      while (!instr_valid && lat < 200) begin
         cyc();
         lat++;
      end
      chk("first_valid_latency", lat, 66);
      chk("hdr_bits", hdr_bits, 32);
      chk("hdr_value", hdr_cap, exp_hdr);
      chk("sck_rises_to_first_bit", sck_rises, 33);
   endtask

   task automatic wait_words(input int n);
      int lat = 0;
      while (wd_cnt < n && lat < n * 64 + 100) begin
         cyc();
         lat++;
      end
      chk("words_done", wd_cnt, n);
   endtask

   task automatic stop_pulse();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("idle_after_stop_busy", busy, 0);
      chk("idle_after_stop_cs", spi_cs_n, 1);
      chk("idle_after_stop_sck", spi_sck, 0);
   endtask

   task automatic stall_window(output int v, output int r);
      logic sp;
      v  = 0;
      r  = 0;
      sp = spi_sck;
      stall = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (instr_valid) v++;
         if (spi_sck && !sp) r++;
         sp = spi_sck;
      end
      stall = 1'b0;
   endtask

   task automatic check_word(input string name, input int idx, input logic [31:0] exp);
      if (rx_words.size() > idx) chk(name, rx_words[idx], exp);
      else chk({name, "_missing"}, rx_words.size(), idx + 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, r, lat;
      vt[0] = '{24'h000103, 32'h03000100, 2, 24'h000104, 24'h000108, 32'hDEADBEEF, 32'h12345678};
      vt[1] = '{24'hFFFFFC, 32'h03FFFFFC, 2, 24'h000000, 24'h000004, 32'h0BADC0DE, 32'hFEEDFACE};
      vt[2] = '{24'h000200, 32'h03000200, 1, 24'h000204, 24'h000204, 32'hCAFEF00D, 32'hCAFEF00D};
      vt[3] = '{24'h123457, 32'h03123454, 1, 24'h123458, 24'h123458, 32'h123454C3, 32'h123454C3};

      rst = 1'b1; pc_load = 1'b0; stop = 1'b0; stall = 1'b0; pc_addr = '0; spi_miso = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      chk("reset_cs_n", spi_cs_n, 1);
      chk("reset_sck", spi_sck, 0);
      chk("reset_mosi", spi_mosi, 0);
      chk("reset_valid", instr_valid, 0);
      chk("reset_word_done", word_done, 0);
      chk("reset_fetch_addr", fetch_addr, 0);
      chk("reset_busy", busy, 0);

      for (int i = 0; i < 4; i++) begin
         start_txn(vt[i].addr, vt[i].hdr, 1'b0);
         wait_words(1);
         chk("fetch_addr_after_word1", fetch_addr, vt[i].fa1);
         wait_words(vt[i].words);
         chk("fetch_addr_end", fetch_addr, vt[i].end_fa);
         check_word("rx_word_first", 0, vt[i].w0);
         check_word("rx_word_last", vt[i].words - 1, vt[i].wl);
         stop_pulse();
      end

      // Stall with SCK high, then with SCK low; the bit stream must be unchanged.
      start_txn(24'h000100, 32'h03000100, 1'b0);
      repeat (9) cyc();
      lat = 0;
      while (!spi_sck && lat < 10) begin cyc(); lat++; end
      stall_window(v, r);
      chk("stall_sck_high_strobes", v, 1);
      chk("stall_sck_high_rises", r, 0);
      chk("stall_sck_held_low", spi_sck, 0);
      repeat (5) cyc();
      lat = 0;
      while (spi_sck && lat < 10) begin cyc(); lat++; end
      stall_window(v, r);
      chk("stall_sck_low_strobes", v, 0);
      chk("stall_sck_low_rises", r, 0);
      wait_words(2);
      check_word("stall_word0", 0, 32'hDEADBEEF);
      check_word("stall_word1", 1, 32'h12345678);
      stop_pulse();

      // Restart mid-ADDR, mid-DATA, and with stop in the same cycle.
      start_txn(24'h000100, 32'h03000100, 1'b0);
      stop_pulse();
      pc_addr = 24'h000100;
      pc_load = 1'b1;
      cyc();
      pc_load = 1'b0;
      repeat (42) cyc();
      chk("mid_addr_cs_low", spi_cs_n, 0);
      start_txn(24'h000200, 32'h03000200, 1'b0);
      wait_words(1);
      check_word("restart_addr_word", 0, 32'hCAFEF00D);
      repeat (30) cyc();
      start_txn(24'h000200, 32'h03000200, 1'b0);
      chk("no_word_done_for_partial", wd_cnt, 0);
      chk("no_partial_word", rx_words.size(), 0);
      wait_words(1);
      check_word("restart_data_word", 0, 32'hCAFEF00D);
      repeat (20) cyc();
      start_txn(24'h000200, 32'h03000200, 1'b1);
      wait_words(1);
      check_word("load_stop_word", 0, 32'hCAFEF00D);

      // Reset mid-DATA, with instr_bit known to be 1 first.
      lat = 0;
      while (!(instr_valid && instr_bit) && lat < 100) begin cyc(); lat++; end
      chk("instr_bit_one_before_reset", instr_bit, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_cs_n", spi_cs_n, 1);
      chk("rst_sck", spi_sck, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_instr_bit", instr_bit, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_word_done", word_done, 0);
      chk("rst_fetch_addr", fetch_addr, 0);
      chk("rst_busy", busy, 0);
      r = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (spi_sck) r++;
      end
      chk("no_sck_after_reset", r, 0);
      chk("cs_high_after_reset", spi_cs_n, 1);

      // Stop while idle changes nothing.
      stop_pulse();
      repeat (5) cyc();
      chk("idle_stop_cs", spi_cs_n, 1);
      chk("idle_stop_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nanov_fetch_ctrl.md
# nanov_fetch_ctrl

Serial instruction fetch sequencer for the nanoV core. It drives an SPI flash (mode 0, standard 0x03 read) to stream instruction bits into the core's one-bit-per-cycle instruction shift input. It restarts the stream on a program-counter load and pauses it on core stall. It sits between the top level and the flash pins, replacing the raw serial pin feed to `nanoV_core`.

## Interface
- `ADDR_BITS`, 24: flash address width sent after the command byte.
- `READ_CMD`, 8'h03: SPI read command byte.
- `CS_GAP`, 2: minimum clk cycles `spi_cs_n` stays high between transactions (≥1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_load`  in  1  one-cycle pulse: abort any transaction and restart the fetch at `pc_addr`.
- `pc_addr`  in  ADDR_BITS  byte address; bits [1:0] are ignored and forced to 0.
- `stop`  in  1  one-cycle pulse: end the transaction and return to idle.
- `stall`  in  1  level: pause the data stream (DATA state only).
- `spi_miso`  in  1  flash serial data out.
- `spi_cs_n`  out  1  flash chip select, active-low.
- `spi_sck`  out  1  flash clock, clk/2, idles low.
- `spi_mosi`  out  1  flash serial data in.
- `instr_bit`  out  1  received instruction bit, to the core shift input.
- `instr_valid`  out  1  one-cycle strobe: `instr_bit` is new.
- `word_done`  out  1  one-cycle strobe, coincident with the 32nd `instr_valid` of each word.
- `fetch_addr`  out  ADDR_BITS  byte address of the word currently being received.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `spi_cs_n`=1, `spi_sck`=0.
  - GAP: count `CS_GAP` cycles with `spi_cs_n`=1.
  - CMD: 8 bits.
  - ADDR: `ADDR_BITS` bits.
  - DATA: unbounded.
- Transitions:
  - IDLE → GAP on `pc_load`.
  - GAP → CMD when the gap count expires.
  - CMD → ADDR after 8 bits.
  - ADDR → DATA after `ADDR_BITS` bits.
  - DATA → DATA continues indefinitely; `stop` goes to IDLE.
- `pc_load` in any state, including GAP and mid-bit, goes to GAP. The `spi_cs_n`=1 and `spi_sck`=0 change is registered at that clk edge. `fetch_addr` ← {`pc_addr`[ADDR_BITS-1:2], 2'b00}.
- `pc_load` and `stop` in the same cycle: `pc_load` wins.
- `stop` in any non-IDLE state goes to IDLE in one edge; a partial word is discarded and produces no `word_done`.
- Shift order:
  - MOSI sends the command, then the address, MSB first.
  - In DATA, bits are delivered in flash order (byte0 bit7 first). The controller does no byte reordering.
- Bit counter runs 0..31 within a word. Each `word_done` advances `fetch_addr` by 4, modulo 2^ADDR_BITS (wraps 0xFFFFFC → 0x000000).
- `stall`:
  - Sampled only in DATA.
  - If `stall`=1 while `spi_sck` is low, `spi_sck` holds low and no bit progresses.
  - If `stall` rises while `spi_sck` is high, the current bit completes (falls low, sample, strobe), then the stream holds.
  - The stream resumes on the first cycle `stall`=0.
- `spi_mosi` is 0 in DATA, GAP and IDLE.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `instr_bit`=0, `instr_valid`=0, `word_done`=0, `fetch_addr`=0, `busy`=0, state IDLE.
- Reset mid-transaction takes effect at that edge with the same values; no further SCK edges follow.
- SPI bit k of a transaction, counting from `spi_cs_n` falling at edge E0:
  - `spi_mosi` is valid from E(2k).
  - `spi_sck` rises at E(2k+1) and falls at E(2k+2).
  - `spi_miso` is sampled at E(2k+2).
- Bit 7 of the command is on `spi_mosi` from E0.
- `pc_load` at edge L puts `spi_cs_n` low at edge L+`CS_GAP`+1.
- The first data bit is sampled at E(2·(8+ADDR_BITS)+2), which is E66 for defaults. `instr_valid` is high for the cycle after that edge.
- With no stall, `instr_valid` pulses every 2 cycles, so one word takes 64 cycles.
- `instr_bit` holds its value between strobes.

## Test plan
- Reset, then `pc_load` with `pc_addr`=0x000103 → `spi_cs_n` low 3 cycles later; MOSI shows 0x03 then 0x000100 MSB first; 32 SCK rising edges before data; first `instr_valid` 66 cycles after CS falls.
- Flash model returns 0xDEADBEEF, 0x12345678 → 64 `instr_bit` strobes matching the flash bit order; `word_done` on strobes 32 and 64; `fetch_addr` 0x000100 → 0x000104 → 0x000108.
- Assert `stall` for 10 cycles mid-word, once while `spi_sck` is high → exactly one further bit completes, then SCK is held low; no strobes while stalled; bit sequence unchanged after resume.
- Issue `pc_load` 0x000200 mid-ADDR, then again mid-DATA, and in the same cycle as `stop` → CS high for ≥2 cycles, new 0x03 + 0x000200 header, no `word_done` for the aborted partial word; the simultaneous case restarts rather than idling.
- Start at 0xFFFFFC and stream 2 words → `fetch_addr` wraps to 0x000000 after the first `word_done`.
- Assert `rst` mid-DATA → next cycle all outputs are at reset values and no SCK edge follows; `stop` in IDLE → no effect.
